// File: rtl/boot_image_loader_if.sv
// Byte-stream input and RAM write port of the boot image loader.
// The master side is the loader; the slave side is the UART front end plus the RAM.
interface boot_image_loader_if #(
  parameter int unsigned MemAddrWidth = 14
) ();

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    mem_req;
  logic                    mem_we;
  logic [MemAddrWidth-1:0] mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_gnt;

  modport master (
    input  rx_data, rx_valid, mem_gnt,
    output rx_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output rx_data, rx_valid, mem_gnt,
    input  rx_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/boot_image_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into SRAM and
// holds the core in reset until the whole image has been written and verified.
module boot_image_loader #(
  parameter int unsigned BaseWordAddr = 32,
  parameter int unsigned MemAddrWidth = 14,
  parameter int unsigned MaxWords     = 4096
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_ni,
  boot_image_loader_if.master     bus_io,
  output logic                    core_rst_no,
  output logic                    boot_done_o,
  output logic                    boot_err_o,
  output logic [MemAddrWidth-1:0] words_loaded_o
);

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 32;
  localparam int unsigned BufW  = 24;

  typedef enum logic [2:0] {
    StHdr,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0]        n_q, n_d;
  logic [BufW-1:0]         word_q, word_d;
  logic [ByteW-1:0]        csum_q, csum_d;
  logic [MemAddrWidth-1:0] words_q, words_d;
  logic [MemAddrWidth-1:0] addr_q, addr_d;
  logic [WordW-1:0]        wdata_q, wdata_d;
  logic                    req_q, req_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    core_rst_n_q, core_rst_n_d;

  logic                    rx_fire;
  logic                    mem_fire;
  logic [WordW-1:0]        hdr_word;
  logic [ByteW-1:0]        rx_byte;

  assign rx_byte  = bus_io.rx_data;
  assign rx_fire  = bus_io.rx_valid && rx_ready_q;
  assign mem_fire = req_q && bus_io.mem_gnt;
  assign hdr_word = {rx_byte, n_q[BufW-1:0]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    n_d          = n_q;
    word_d       = word_q;
    csum_d       = csum_q;
    words_d      = words_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      StHdr: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: n_d[7:0]   = rx_byte;
            2'd1: n_d[15:8]  = rx_byte;
            2'd2: n_d[23:16] = rx_byte;
            default: begin
              n_d = hdr_word;
              if (hdr_word > WordW'(MaxWords)) begin
                state_d = StErr;
              end else if (hdr_word == '0) begin
                state_d = StCsum;
              end else begin
                state_d = StData;
              end
            end
          endcase
        end
      end

      StData: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          csum_d     = csum_q ^ rx_byte;
          unique case (byte_cnt_q)
            2'd0: word_d[7:0]   = rx_byte;
            2'd1: word_d[15:8]  = rx_byte;
            2'd2: word_d[23:16] = rx_byte;
            default: begin
              wdata_d = {rx_byte, word_q};
              addr_d  = MemAddrWidth'(BaseWordAddr) + words_q;
              state_d = StWrite;
            end
          endcase
        end
      end

      // Address and data stay frozen in addr_q/wdata_q until the grant
      StWrite: begin
        if (mem_fire) begin
          words_d = words_q + MemAddrWidth'(1);
          if (WordW'(words_q) + WordW'(1) == n_q) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end

      StCsum: begin
        if (rx_fire) begin
          state_d = (rx_byte == csum_q) ? StDone : StErr;
        end
      end

      StDone: state_d = StDone;
      StErr:  state_d = StErr;
      default: state_d = StErr;
    endcase

    rx_ready_d   = (state_d == StHdr) || (state_d == StData) || (state_d == StCsum);
    req_d        = (state_d == StWrite);
    done_d       = (state_d == StDone);
    core_rst_n_d = (state_d == StDone);
    err_d        = (state_d == StErr);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q      <= StHdr;
      byte_cnt_q   <= '0;
      n_q          <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      rx_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      n_q          <= n_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      rx_ready_q   <= rx_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign bus_io.rx_ready  = rx_ready_q;
  assign bus_io.mem_req   = req_q;
  assign bus_io.mem_we    = req_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_wdata = wdata_q;
  assign bus_io.mem_be    = {4{req_q}};

  assign core_rst_no    = core_rst_n_q;
  assign boot_done_o    = done_q;
  assign boot_err_o     = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench for boot_image_loader: a byte driver, a grant responder and a
// write monitor that checks RAM writes against a queue of expected writes.
module tb_boot_image_loader;

  localparam int unsigned AW   = 14;
  localparam int unsigned BASE = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_rst_n;
  logic          boot_done;
  logic          boot_err;
  logic [AW-1:0] words_loaded;

  boot_image_loader_if #(.MemAddrWidth(AW)) bus ();

  boot_image_loader #(
    .BaseWordAddr(BASE),
    .MemAddrWidth(AW),
    .MaxWords    (4096)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .bus_io        (bus),
    .core_rst_no   (core_rst_n),
    .boot_done_o   (boot_done),
    .boot_err_o    (boot_err),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          gnt_delay = 0;
  wr_t         exp_q[$];
  logic [31:0] ram [int];
  logic [31:0] img [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_rd(input int a);
    return ram.exists(a) ? ram[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"},  32'(bus.mem_req),   32'd0);
    chk({tag, "_mem_we"},   32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,     32'd0);
    chk({tag, "_mem_be"},   32'(bus.mem_be),    32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst_n),    32'd0);
    chk({tag, "_done"},     32'(boot_done),     32'd0);
    chk({tag, "_err"},      32'(boot_err),      32'd0);
    chk({tag, "_words"},    32'(words_loaded),  32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready),  32'd1);
  endtask

  // Entered and left on a falling edge
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals(tag);
    exp_q.delete();
    ram.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one byte and returns on the falling edge after it was taken
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rx_ready) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL byte_accept_timeout: byte %h not taken within 200 cycles", b);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_data_word(input int idx, input logic [31:0] w);
    wr_t e;
    e.addr = AW'(BASE + idx);
    e.data = w;
    exp_q.push_back(e);
    send_word32(w);
  endtask

  task automatic load_std_image(input string tag);
    send_word32(32'd3);
    for (int i = 0; i < 3; i++) send_data_word(i, img[i]);
    chk({tag, "_core_rst_before_csum"}, 32'(core_rst_n), 32'd0);
    send_byte(8'h13);
    chk({tag, "_done"},      32'(boot_done),    32'd1);
    chk({tag, "_core_rst"},  32'(core_rst_n),   32'd1);
    chk({tag, "_err"},       32'(boot_err),     32'd0);
    chk({tag, "_rx_ready"},  32'(bus.rx_ready), 32'd0);
    chk({tag, "_words"},     32'(words_loaded), 32'd3);
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
    chk({tag, "_ram32"}, ram_rd(32), 32'h1234_50B7);
    chk({tag, "_ram33"}, ram_rd(33), 32'h6780_8093);
    chk({tag, "_ram34"}, ram_rd(34), 32'h0000_1137);
  endtask

  // Grant responder: updates between edges, tied high when gnt_delay is 0
  task automatic gnt_proc();
    int cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus.mem_req) begin
        cnt = 0;
        bus.mem_gnt = (gnt_delay == 0);
      end else begin
        cnt++;
        bus.mem_gnt = (gnt_delay == 0) || (cnt >= gnt_delay);
      end
    end
  endtask

  // Write monitor: checks held request fields and pops the scoreboard on grant
  task automatic mon_proc();
    logic          holding = 1'b0;
    logic [AW-1:0] ha = '0;
    logic [31:0]   hd = '0;
    wr_t           e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req) begin
        chk("mem_be",   32'(bus.mem_be),   32'hF);
        chk("mem_we",   32'(bus.mem_we),   32'd1);
        chk("rx_ready_during_write", 32'(bus.rx_ready), 32'd0);
        if (holding) begin
          chk("hold_addr", 32'(bus.mem_addr), 32'(ha));
          chk("hold_data", bus.mem_wdata, hd);
        end
        if (bus.mem_gnt) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", bus.mem_addr, bus.mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("write_data", bus.mem_wdata, e.data);
          end
          ram[int'(bus.mem_addr)] = bus.mem_wdata;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          ha = bus.mem_addr;
          hd = bus.mem_wdata;
        end
      end else begin
        holding = 1'b0;
      end
    end
  endtask

  initial begin
    img[0] = 32'h1234_50B7;
    img[1] = 32'h6780_8093;
    img[2] = 32'h0000_1137;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.mem_gnt  = 1'b0;

    fork
      gnt_proc();
      mon_proc();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Three words, grant tied high
    gnt_delay = 0;
    apply_reset("rst0");
    load_std_image("img_fast");

    // Same image, grant delayed
    gnt_delay = 5;
    apply_reset("rst1");
    load_std_image("img_slow");

    // Empty image, good and bad checksum
    gnt_delay = 0;
    apply_reset("rst2");
    send_word32(32'd0);
    send_byte(8'h00);
    chk("n0_done",  32'(boot_done),  32'd1);
    chk("n0_core",  32'(core_rst_n), 32'd1);
    chk("n0_words", 32'(words_loaded), 32'd0);

    apply_reset("rst3");
    send_word32(32'd0);
    send_byte(8'h01);
    chk("n0bad_err",  32'(boot_err),   32'd1);
    chk("n0bad_core", 32'(core_rst_n), 32'd0);
    chk("n0bad_done", 32'(boot_done),  32'd0);

    // One word with wrong checksum
    apply_reset("rst4");
    send_word32(32'd1);
    send_data_word(0, 32'h0000_005D);
    send_byte(8'h00);
    chk("n1bad_err",     32'(boot_err),   32'd1);
    chk("n1bad_written", ram_rd(32),      32'h0000_005D);
    repeat (4) @(negedge clk);
    chk("n1bad_err_sticky", 32'(boot_err),     32'd1);
    chk("n1bad_rx_ready",   32'(bus.rx_ready), 32'd0);
    chk("n1bad_core",       32'(core_rst_n),   32'd0);

    // Oversized header
    apply_reset("rst5");
    send_word32(32'd4097);
    chk("big_err",      32'(boot_err),     32'd1);
    chk("big_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("big_no_req",  32'(bus.mem_req),  32'd0);
    chk("big_words",   32'(words_loaded), 32'd0);

    // Reset while the second word's write is waiting for grant
    gnt_delay = 5;
    apply_reset("rst6");
    send_word32(32'd3);
    send_data_word(0, img[0]);
    send_data_word(1, img[1]);
    chk("mid_req_pending", 32'(bus.mem_req),  32'd1);
    chk("mid_words",       32'(words_loaded), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    ram.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    load_std_image("img_after_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_image_loader.md
# boot_image_loader

- Streams a program image from a byte source (UART RX front end) into the SoC SRAM through the RAM write port.
- Holds the core in reset until the whole image has been written and its checksum verified.
- Sits upstream of the core and RAM in the SoC top. It is the synthesizable replacement for preloading memory by hex file; images land at word offset 32 by default.

## Interface

Parameters:

- BaseWordAddr, 32, RAM word address where payload word 0 is written.
- MemAddrWidth, 14, width of the word address to RAM.
- MaxWords, 4096, largest accepted word count; a header above this is an error.

Ports:

- clk_sys_i  in  1  system clock; the only clock.
- rst_sys_ni  in  1  asynchronous active-low reset.
- rx_data_i  in  8  incoming image byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  loader can accept a byte; transfer happens when valid && ready.
- mem_req_o  out  1  RAM write request.
- mem_we_o  out  1  write enable; equals mem_req_o.
- mem_addr_o  out  MemAddrWidth  RAM word address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables; always 4'hF while requesting, else 0.
- mem_gnt_i  in  1  RAM accepts the request in this cycle.
- core_rst_no  out  1  active-low reset to the core.
- boot_done_o  out  1  image loaded and checksum good (sticky).
- boot_err_o  out  1  length or checksum error (sticky).
- words_loaded_o  out  MemAddrWidth  count of words written so far.

## Operation

- Image format, all values little-endian:
  - 4 header bytes giving word count N.
  - 4·N payload bytes.
  - 1 checksum byte: XOR of all payload bytes; equals 0x00 when N=0.
- States: HDR, DATA, WRITE, CSUM, DONE, ERR.
- HDR: collect 4 bytes into N.
  - N > MaxWords → ERR.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA: shift each byte into the word buffer (byte k → bits 8k+7:8k), XOR it into the running checksum, and increment a 2-bit byte counter. On the 4th byte → WRITE.
- WRITE:
  - Assert mem_req_o with addr = BaseWordAddr + words_loaded_o; data and address are held stable until mem_gnt_i.
  - In the gnt cycle, words_loaded_o increments.
  - Next state: CSUM if words_loaded_o+1 == N, else DATA.
- CSUM: accept 1 byte. Equal to the running checksum → DONE, else ERR.
- DONE: boot_done_o=1, core_rst_no=1, rx_ready_o=0. Terminal until reset.
- ERR: boot_err_o=1, core_rst_no=0, rx_ready_o=0. Terminal until reset.
- Arithmetic:
  - Address addition truncates to MemAddrWidth (wrap).
  - The header N is compared at 32 bits before any truncation.

## Timing

- Reset values of all outputs:
  - 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, core_rst_no, boot_done_o, boot_err_o, words_loaded_o.
  - 1: rx_ready_o (state HDR).
- rx_ready_o is 1 in HDR, DATA and CSUM, and 0 in WRITE, DONE and ERR. It is registered: it drops in the cycle after the 4th data byte is accepted.
- mem_req_o rises the cycle after the 4th byte of a word is accepted and falls the cycle after mem_gnt_i.
  - With gnt tied high, each word costs exactly 1 write cycle.
  - rx_ready_o returns to 1 the cycle after gnt.
- mem_gnt_i is ignored when mem_req_o=0.
- core_rst_no and boot_done_o rise in the cycle after a matching checksum byte is accepted.
- boot_err_o rises in the cycle after the offending header or checksum byte is accepted.
- Asserting rst_sys_ni low mid-load, including mid-WRITE:
  - Immediately clears state, counters and outputs.
  - Drops mem_req_o without waiting for gnt.
  - core_rst_no goes low asynchronously.
- Bytes presented while rx_ready_o=0 are not consumed; the source must hold them.

## Test plan

- N=3, payload words 0x123450B7, 0x67808093, 0x00001137, correct checksum, gnt tied high → three writes to word addresses 32, 33, 34 with those data and be=F; core_rst_no=1 and boot_done_o=1 one cycle after the checksum byte.
- Same image, gnt delayed 5 cycles per request → addr and data stable for the full hold; rx_ready_o=0 throughout; no byte lost; identical final RAM contents.
- N=0, checksum byte 0x00 → no mem_req_o; boot_done_o=1. Checksum byte 0x01 instead → boot_err_o=1, core_rst_no stays 0.
- N=1, word 0x0000005D, checksum byte 0x00 (true checksum 0x5D) → one write to addr 32, then boot_err_o=1; rx_ready_o=0 and core_rst_no=0 thereafter.
- Header N=MaxWords+1 → boot_err_o=1 after the 4th header byte; no RAM write.
- rst_sys_ni pulsed low while mem_req_o=1 on word 2 → all outputs immediately at reset values; a fresh full image then loads correctly from addr 32.
